// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// Helpers work on MAX_W-bit values; callers zero-extend their operands and
// size-cast the result back, so the divider supports WIDTH up to MAX_W.
package div_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One divide request as seen by the ALU op decoder.
    typedef struct packed {
        logic             is_signed;
        logic [MAX_W-1:0] dividend;
        logic [MAX_W-1:0] divisor;
    } div_req_t;

    // Two's-complement negate; the low WIDTH bits equal a WIDTH-bit negate.
    function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] v);
        return ~v + {{(MAX_W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude: negate when the operand is flagged as negative.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                               input logic            is_neg);
        return is_neg ? neg_w(v) : v;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider, signed or unsigned per op.
// Optional macro SEQ_DIV_BYPASS_EN: divide-by-zero, divide-by-one and
// |dividend| < |divisor| finish one cycle after accept without iterating.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE, so one op is in flight at a
// time. out_valid stays high with quotient/remainder/div_by_zero stable until
// out_ready is seen; the result registers keep their value afterwards until
// the next op completes.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output state_t           state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;       // signed partial remainder
    logic [WIDTH-1:0] q_reg;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] m;         // divisor magnitude
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [WIDTH-1:0] dvd_raw;   // returned untouched as remainder on divide by zero

    logic             accept;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvr_mag;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign accept    = in_valid && (state == IDLE);
    assign state_dbg = state;

    // Operand magnitudes; sign bits only matter in signed mode.
    assign dvd_mag = WIDTH'(abs_w(MAX_W'(dividend), in_signed & dividend[WIDTH-1]));
    assign dvr_mag = WIDTH'(abs_w(MAX_W'(divisor),  in_signed & divisor[WIDTH-1]));

    // One non-restoring iteration: shift, then add or subtract by the old acc sign.
    always_comb begin
        acc_sh   = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        step_acc = acc[WIDTH] ? (acc_sh + {1'b0, m}) : (acc_sh - {1'b0, m});
        step_q   = {q_reg[WIDTH-2:0], ~step_acc[WIDTH]};
    end

    // Final correction and sign application; divide by zero overrides both.
    always_comb begin
        r_mag   = acc[WIDTH] ? WIDTH'(acc + {1'b0, m}) : acc[WIDTH-1:0];
        q_final = neg_q ? WIDTH'(neg_w(MAX_W'(q_reg))) : q_reg;
        r_final = neg_r ? WIDTH'(neg_w(MAX_W'(r_mag))) : r_mag;
        if (dz) begin
            q_final = '1;
            r_final = dvd_raw;
        end
    end

`ifdef SEQ_DIV_BYPASS_EN
    logic             bypass_hit;
    logic [WIDTH-1:0] byp_q;
    logic [WIDTH-1:0] byp_r;
    logic             byp_dz;

    // Trivial ops whose result is known from the operands alone.
    always_comb begin
        bypass_hit = 1'b0;
        byp_q      = '0;
        byp_r      = '0;
        byp_dz     = 1'b0;
        if (divisor == '0) begin
            bypass_hit = 1'b1;
            byp_q      = '1;
            byp_r      = dividend;
            byp_dz     = 1'b1;
        end else if (divisor == WIDTH'(1)) begin
            bypass_hit = 1'b1;
            byp_q      = dividend;
        end else if (dvd_mag < dvr_mag) begin
            bypass_hit = 1'b1;
            byp_r      = dividend;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = RUN;
`ifdef SEQ_DIV_BYPASS_EN
                    if (bypass_hit) state_nxt = DONE;
`endif
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands at accept, iterate in RUN, publish results in FIX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            acc         <= '0;
            q_reg       <= '0;
            m           <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            dvd_raw     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        acc     <= '0;
                        q_reg   <= dvd_mag;
                        m       <= dvr_mag;
                        neg_q   <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r   <= in_signed & dividend[WIDTH-1];
                        dz      <= (divisor == '0);
                        dvd_raw <= dividend;
`ifdef SEQ_DIV_BYPASS_EN
                        if (bypass_hit) begin
                            quotient    <= byp_q;
                            remainder   <= byp_r;
                            div_by_zero <= byp_dz;
                        end
`endif
                    end
                end
                RUN: begin
                    acc   <= step_acc;
                    q_reg <= step_q;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quotient    <= q_final;
                    remainder   <= r_final;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8), default or bypass build.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;
    state_t       state_dbg;

    int checks = 0;
    int errors = 0;

    // {div_by_zero, quotient, remainder}
    logic [2*W:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result from integer arithmetic (truncating division).
    function automatic logic [2*W:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib, iq, ir;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (sgn) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        iq = ia / ib;
        ir = ia % ib;
        return {1'b0, W'(iq), W'(ir)};
    endfunction

    // Expected latency as a cycle index, accept cycle = 0.
    function automatic int model_latency(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        int lat;
        lat = W + 2;
`ifdef SEQ_DIV_BYPASS_EN
        ia = sgn ? int'($signed(a)) : int'(a);
        ib = sgn ? int'($signed(b)) : int'(b);
        if (ia < 0) ia = -ia;
        if (ib < 0) ib = -ib;
        if (b == '0 || ib == 1 && !(sgn && b[W-1]) || ia < ib) lat = 1;
`else
        ia = int'(a);
        ib = int'(b);
        if (sgn && ia < 0 && ib < 0) lat = W + 2;
`endif
        return lat;
    endfunction

    // driver: one full op with optional result backpressure
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [2*W:0] exp;
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) begin
            check("in_ready_wait", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid  = 1'b1;
        in_signed = sgn;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b0;
        exp_q.push_back(model(sgn, a, b));
        step();
        in_valid = 1'b0;
        dividend = $urandom_range(0, 255);
        divisor  = $urandom_range(0, 255);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(model_latency(sgn, a, b)));
        exp = exp_q.pop_front();
        if (!out_valid) return;
        check("quotient", 64'(quotient), 64'(exp[2*W-1:W]));
        check("remainder", 64'(remainder), 64'(exp[W-1:0]));
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp[2*W]});
        for (int i = 0; i < hold; i++) begin
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_quotient", 64'(quotient), 64'(exp[2*W-1:W]));
            check("hold_remainder", 64'(remainder), 64'(exp[W-1:0]));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_valid", {63'd0, out_valid}, 64'd0);
        check("post_quotient", 64'(quotient), 64'(exp[2*W-1:W]));
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dz", {63'd0, div_by_zero}, 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        reset_n = 1'b1;
        step();

        // directed cases
        run_op(1'b0, 8'd200, 8'd7,   0);
        run_op(1'b1, 8'hF9,  8'd2,   0);
        run_op(1'b1, 8'd7,   8'hFE,  0);
        run_op(1'b0, 8'h5A,  8'd0,   0);
        run_op(1'b1, 8'h5A,  8'd0,   0);
        run_op(1'b1, 8'hA6,  8'd0,   0);
        run_op(1'b1, 8'h80,  8'hFF,  0);
        run_op(1'b0, 8'h80,  8'hFF,  0);
        run_op(1'b0, 8'd3,   8'd9,   0);
        run_op(1'b0, 8'd77,  8'd5,   5);
        run_op(1'b1, 8'h80,  8'd1,   0);
        run_op(1'b0, 8'hFF,  8'd1,   0);
        run_op(1'b1, 8'hFF,  8'hFF,  1);
        run_op(1'b0, 8'hFF,  8'hFF,  0);
        run_op(1'b1, 8'h85,  8'd3,   0);

        // abort an op mid-RUN at cnt=3
        in_valid  = 1'b1;
        in_signed = 1'b0;
        dividend  = 8'd200;
        divisor   = 8'd7;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check("abort_state_run", 64'(state_dbg), 64'(RUN));
        reset_n = 1'b0;
        #1;
        check("abort_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_rst_busy", {63'd0, busy}, 64'd0);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * W + 4; i++) begin
            check("abort_no_valid", {63'd0, out_valid}, 64'd0);
            step();
        end
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_quotient", 64'(quotient), 64'd0);
        out_ready = 1'b0;

        // random ops
        repeat (40) begin
            logic         s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            s = 1'($urandom_range(0, 1));
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
            run_op(s, a, b, $urandom_range(0, 2));
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
